// File: rtl/noc_output_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_output_arbiter_pkg : flit types and port count shared by the arbiter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package noc_output_arbiter_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PAYLOAD_W = 32;

   typedef enum logic [1:0] {
      HEAD   = 2'd0,
      BODY   = 2'd1,
      TAIL   = 2'd2,
      SINGLE = 2'd3
   } flit_kind_t;

   typedef struct packed {
      flit_kind_t             kind;
      logic [PAYLOAD_W-1:0]   payload;
   } flit_t;

   // HEAD and SINGLE are the only kinds allowed to open a packet.
   function automatic logic is_start(input flit_kind_t k);
      return (k == HEAD) || (k == SINGLE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/noc_output_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first request at/after ptr  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NUM_INPUTS = 5,
   parameter int PTR_W      = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [PTR_W-1:0]      ptr,
   output logic [NUM_INPUTS-1:0] gnt,
   output logic [PTR_W-1:0]      gnt_idx,
   output logic                  any_gnt
);

   logic [PTR_W-1:0] w_idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         w_idx = PTR_W'((int'(ptr) + k) % NUM_INPUTS);
         if (!any_gnt && req[w_idx]) begin
            any_gnt    = 1'b1;
            gnt_idx    = w_idx;
            gnt[w_idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/noc_output_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_output_arbiter : round-robin output port share with wormhole lock    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module noc_output_arbiter
   import noc_output_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = NUM_PORTS,
   parameter int PTR_W      = $clog2(NUM_INPUTS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_INPUTS-1:0]  in_valid,
   input  flit_t [NUM_INPUTS-1:0] in_flit,
   output logic [NUM_INPUTS-1:0]  in_ready,
   output logic                   out_valid,
   output flit_t                  out_flit,
   input  logic                   out_ready,
   output logic                   locked,
   output logic [PTR_W-1:0]       owner,
   output logic                   err_protocol
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]            r_state;
   logic [PTR_W-1:0]      r_rr_ptr;
   logic [PTR_W-1:0]      r_owner;
   logic                  r_out_valid;
   flit_t                 r_out_flit;
   logic                  r_err;

   logic                  w_load_en;
   logic [NUM_INPUTS-1:0] w_req;
   logic [NUM_INPUTS-1:0] w_bad;
   logic [NUM_INPUTS-1:0] w_gnt;
   logic [PTR_W-1:0]      w_gnt_idx;
   logic                  w_any_gnt;
   flit_t                 w_owner_flit;
   logic                  w_owner_ok;
   logic                  w_err_idle;
   logic                  w_err_owner;
   logic                  w_xfer;
   flit_t                 w_sel_flit;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] idx);
      return (idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : idx + PTR_W'(1);
   endfunction

   generate
      for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
         assign w_req[i] = in_valid[i] &&  is_start(in_flit[i].kind);
         assign w_bad[i] = in_valid[i] && !is_start(in_flit[i].kind);
      end
   endgenerate

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS),
      .PTR_W      (PTR_W)
   ) u_rr_arbiter (
      .req     (w_req),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any_gnt (w_any_gnt)
   );

   assign w_load_en    = !r_out_valid || out_ready;
   assign w_owner_flit = in_flit[r_owner];
   // While locked the owner may only continue its packet with BODY/TAIL.
   assign w_owner_ok   = in_valid[r_owner] && !is_start(w_owner_flit.kind);
   assign w_err_idle   = (r_state == ST_IDLE) && (|w_bad);
   assign w_err_owner  = (r_state == ST_LOCKED) && in_valid[r_owner] &&
                         is_start(w_owner_flit.kind);
   assign w_xfer       = |in_ready;
   assign w_sel_flit   = (r_state == ST_LOCKED) ? w_owner_flit : in_flit[w_gnt_idx];

   always_comb begin
      in_ready = '0;
      if (!rst && w_load_en) begin
         if (r_state == ST_LOCKED) begin
            if (w_owner_ok) in_ready[r_owner] = 1'b1;
         end else if (w_any_gnt) begin
            in_ready = w_gnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_out_valid <= 1'b0;
         r_out_flit  <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_err_idle || w_err_owner) r_err <= 1'b1;
         if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) r_out_flit <= w_sel_flit;
         end
         // The pointer moves only when a packet completes (SINGLE or TAIL).
         if (w_xfer) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_sel_flit.kind == HEAD) begin
                     r_state <= ST_LOCKED;
                     r_owner <= w_gnt_idx;
                  end else begin
                     r_rr_ptr <= f_next(w_gnt_idx);
                  end
               end
               default: begin
                  if (w_sel_flit.kind == TAIL) begin
                     r_state  <= ST_IDLE;
                     r_rr_ptr <= f_next(r_owner);
                  end
               end
            endcase
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_flit     = r_out_flit;
   assign locked       = (r_state == ST_LOCKED);
   assign owner        = r_owner;
   assign err_protocol = r_err;

endmodule
`default_nettype wire
